cook_timer_ctrl: RTL and testbench
==================================

// Module: cook_timer_ctrl
// PURPOSE
//   Countdown-timer controller: sequences a BCD MM:SS down-counter datapath
//   driven by the shared 1 s strobe from the clock-divider chain. Owns the
//   set / run / pause / alarm FSM, preset capture and alarm timeout. Output
//   digits feed the FND scan driver; alarm drives buzzer/LED.
// PARAMETERS
//   ALARM_SEC  5  alarm duration in clk_sec strobes before auto-return to IDLE (1..15)
// PORTS
//   clk        in   1  system clock; single clock domain
//   reset_p    in   1  reset, synchronous, active-high
//   clk_sec    in   1  one-cycle strobe, once per second
//   btn_start  in   1  one-cycle pulse (edge-detected upstream): start/pause toggle
//   btn_min    in   1  one-cycle pulse: minutes +1
//   btn_sec    in   1  one-cycle pulse: seconds +1
//   btn_clear  in   1  one-cycle pulse: abort and zero
//   min10      out  4  BCD minutes tens (0..5)
//   min1       out  4  BCD minutes ones (0..9)
//   sec10      out  4  BCD seconds tens (0..5)
//   sec1       out  4  BCD seconds ones (0..9)
//   state      out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 ALARM
//   alarm      out  1  high throughout ALARM
//   done       out  1  one-cycle pulse on the RUN->ALARM transition
// BEHAVIOUR
// - All outputs registered. Reset (sync, clk edge): state=IDLE, digits=00:00,
//   preset=00:00, alarm=0, done=0, alarm counter=0.
// - Per-cycle priority: reset_p > btn_clear > btn_start > btn_min > btn_sec > clk_sec.
// - btn_clear (any state): -> IDLE, digits=00:00, preset=00:00, next cycle.
// - IDLE: btn_min: min +1, 59->00, no effect on sec. btn_sec: sec +1, 59->00,
//   no carry into min. btn_start with time!=00:00: preset<=time, -> RUN.
//   btn_start at 00:00: ignored. clk_sec ignored.
// - RUN: each clk_sec decrements MM:SS by 1 BCD: sec1 0->9 borrows sec10;
//   sec10 0->5 borrows min; min 00 never underflows. Strobe seeing 00:01
//   writes 00:00, enters ALARM, asserts done same edge. btn_start -> PAUSE;
//   a clk_sec in that same cycle is dropped. btn_min/btn_sec ignored.
// - PAUSE: digits frozen; clk_sec/btn_min/btn_sec ignored; btn_start -> RUN.
// - ALARM: alarm=1, digits 00:00. Counts clk_sec; on ALARM_SEC-th strobe
//   -> IDLE with digits<=preset. Any of btn_start/btn_min/btn_sec also exits
//   -> IDLE with preset reload (button's own action not applied that cycle).
// - Latency: every button/strobe effect visible on outputs 1 cycle later.
// - Digits never leave legal BCD ranges; no state reachable with invalid BCD.
// - reset_p mid-RUN/ALARM: full reset values next edge, preset lost.
// STRUCTURE
// - Package cook_timer_pkg: state encodings (ST_IDLE..ST_ALARM), BCD limits
//   (SEC10_MAX=5, DIG_MAX=9), ALARM_SEC bound.
// - Sub-module bcd_mmss_down: 4-digit loadable BCD MM:SS counter with
//   load, dec, inc_min, inc_sec controls, zero and one flags; FSM in top.
// - Alarm counter 4 bit; preset register 16 bit.
// TESTING
// - Reset, 3x btn_min, 2x btn_sec, btn_start -> state=RUN, 03:02; after 1
//   clk_sec 03:01; after 2 more 02:59 (borrow across sec10 and min).
// - Set 00:02, start, 2 clk_sec -> 00:00, done=1 one cycle, state=ALARM,
//   alarm=1; 5 clk_sec -> IDLE, digits 00:02, alarm=0.
// - RUN at 01:00, btn_start and clk_sec same cycle -> PAUSE, still 01:00;
//   3 clk_sec -> unchanged; btn_start -> RUN; next clk_sec -> 00:59.
// - IDLE 59:59: btn_sec -> 59:00; btn_min -> 00:00; btn_start -> stays IDLE.
// - RUN at 10:00: btn_clear with btn_start same cycle -> IDLE 00:00; then
//   btn_start -> still IDLE (preset cleared).
// - ALARM: btn_min -> IDLE with preset, min not incremented; reset_p in RUN
//   -> IDLE 00:00, alarm=0 next edge.

Source files
------------

// File: rtl/cook_timer_pkg.sv
// Shared definitions for the cook timer: state encodings, BCD digit limits
// and the alarm-duration bounds.
package cook_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ALARM = 2'b11
  } state_t;

  // Largest legal value of a tens digit (minutes or seconds) and of a ones digit.
  localparam logic [3:0] SEC10_MAX = 4'd5;
  localparam logic [3:0] DIG_MAX   = 4'd9;

  // Alarm duration in 1 s strobes; the alarm counter is 4 bits wide.
  localparam int ALARM_SEC_DEF = 5;
  localparam int ALARM_SEC_MIN = 1;
  localparam int ALARM_SEC_MAX = 15;

endpackage

// File: rtl/cook_timer_ctrl_if.sv
// Bus between the button/strobe front end and the display/buzzer side.
// Signalling: every input here is a one-cycle pulse with no ready/ack; the
// controller samples it on the next clk edge and its effect shows on the
// registered outputs one cycle later. Outputs are level signals except done,
// which is a one-cycle pulse.
interface cook_timer_ctrl_if;
  logic       clk_sec;
  logic       btn_start;
  logic       btn_min;
  logic       btn_sec;
  logic       btn_clear;
  logic [3:0] min10;
  logic [3:0] min1;
  logic [3:0] sec10;
  logic [3:0] sec1;
  logic [1:0] state;
  logic       alarm;
  logic       done;

  // Front end / testbench side.
  modport master (
    output clk_sec, btn_start, btn_min, btn_sec, btn_clear,
    input  min10, min1, sec10, sec1, state, alarm, done
  );

  // Controller side.
  modport slave (
    input  clk_sec, btn_start, btn_min, btn_sec, btn_clear,
    output min10, min1, sec10, sec1, state, alarm, done
  );
endinterface

// File: rtl/cook_timer_ctrl_bcd_mmss_down.sv
// Four-digit BCD MM:SS register with clear, parallel load, one-second
// decrement and independent minute/second increments that wrap 59->00.
// At most one control is expected per cycle; if several arrive the order
// is clear > load > dec > inc_min > inc_sec.
module bcd_mmss_down
  import cook_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_p,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  input  logic        inc_min,
  input  logic        inc_sec,
  output logic [3:0]  min10,
  output logic [3:0]  min1,
  output logic [3:0]  sec10,
  output logic [3:0]  sec1,
  output logic        zero,
  output logic        one
);

  logic [3:0] min10_q, min1_q, sec10_q, sec1_q;

  // Digit registers: apply the single highest-priority control each cycle.
  always_ff @(posedge clk) begin
    if (reset_p || clear) begin
      min10_q <= 4'd0;
      min1_q  <= 4'd0;
      sec10_q <= 4'd0;
      sec1_q  <= 4'd0;
    end else if (load) begin
      min10_q <= load_val[15:12];
      min1_q  <= load_val[11:8];
      sec10_q <= load_val[7:4];
      sec1_q  <= load_val[3:0];
    end else if (dec) begin
      // Borrow chain; 00:00 holds rather than wrapping.
      if (sec1_q != 4'd0) begin
        sec1_q <= sec1_q - 4'd1;
      end else if (sec10_q != 4'd0) begin
        sec10_q <= sec10_q - 4'd1;
        sec1_q  <= DIG_MAX;
      end else if (min1_q != 4'd0) begin
        min1_q  <= min1_q - 4'd1;
        sec10_q <= SEC10_MAX;
        sec1_q  <= DIG_MAX;
      end else if (min10_q != 4'd0) begin
        min10_q <= min10_q - 4'd1;
        min1_q  <= DIG_MAX;
        sec10_q <= SEC10_MAX;
        sec1_q  <= DIG_MAX;
      end
    end else if (inc_min) begin
      if (min1_q == DIG_MAX) begin
        min1_q  <= 4'd0;
        min10_q <= (min10_q == SEC10_MAX) ? 4'd0 : min10_q + 4'd1;
      end else begin
        min1_q <= min1_q + 4'd1;
      end
    end else if (inc_sec) begin
      // Seconds wrap on their own; no carry into minutes.
      if (sec1_q == DIG_MAX) begin
        sec1_q  <= 4'd0;
        sec10_q <= (sec10_q == SEC10_MAX) ? 4'd0 : sec10_q + 4'd1;
      end else begin
        sec1_q <= sec1_q + 4'd1;
      end
    end
  end

  assign min10 = min10_q;
  assign min1  = min1_q;
  assign sec10 = sec10_q;
  assign sec1  = sec1_q;
  assign zero  = ({min10_q, min1_q, sec10_q, sec1_q} == 16'h0000);
  assign one   = ({min10_q, min1_q, sec10_q, sec1_q} == 16'h0001);

endmodule

// File: rtl/cook_timer_ctrl.sv
// Countdown timer controller: set / run / pause / alarm sequencing around a
// BCD MM:SS down counter, with preset capture on start and an alarm that
// times out after ALARM_SEC one-second strobes.
module cook_timer_ctrl
  import cook_timer_pkg::*;
#(
  parameter int ALARM_SEC = ALARM_SEC_DEF
) (
  input  logic                clk,
  input  logic                reset_p,
  cook_timer_ctrl_if.slave    bus
);

  // Out-of-range settings are clamped into what the 4-bit counter can hold.
  localparam int ALARM_N = (ALARM_SEC > ALARM_SEC_MAX) ? ALARM_SEC_MAX :
                           (ALARM_SEC < ALARM_SEC_MIN) ? ALARM_SEC_MIN : ALARM_SEC;
  localparam logic [3:0] ALARM_LAST = 4'(ALARM_N - 1);

  state_t      state_q, state_n;
  logic [15:0] preset_q, preset_n;
  logic [3:0]  alarm_cnt_q, alarm_cnt_n;
  logic        alarm_q, done_q, done_n;

  logic        cnt_clear, cnt_load, cnt_dec, cnt_inc_min, cnt_inc_sec;
  logic        cnt_zero, cnt_one;
  logic [3:0]  min10, min1, sec10, sec1;

  bcd_mmss_down u_cnt (
    .clk      (clk),
    .reset_p  (reset_p),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (preset_q),
    .dec      (cnt_dec),
    .inc_min  (cnt_inc_min),
    .inc_sec  (cnt_inc_sec),
    .min10    (min10),
    .min1     (min1),
    .sec10    (sec10),
    .sec1     (sec1),
    .zero     (cnt_zero),
    .one      (cnt_one)
  );

  // State, preset, alarm counter and the registered alarm/done outputs.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q     <= ST_IDLE;
      preset_q    <= 16'h0000;
      alarm_cnt_q <= 4'd0;
      alarm_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      preset_q    <= preset_n;
      alarm_cnt_q <= alarm_cnt_n;
      alarm_q     <= (state_n == ST_ALARM);
      done_q      <= done_n;
    end
  end

  // Next state and counter controls; inputs are decoded in the order
  // btn_clear > btn_start > btn_min > btn_sec > clk_sec, one action per cycle.
  always_comb begin
    state_n     = state_q;
    preset_n    = preset_q;
    alarm_cnt_n = alarm_cnt_q;
    done_n      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    cnt_inc_min = 1'b0;
    cnt_inc_sec = 1'b0;

    if (bus.btn_clear) begin
      state_n     = ST_IDLE;
      preset_n    = 16'h0000;
      alarm_cnt_n = 4'd0;
      cnt_clear   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // A start at 00:00 is swallowed, not passed down to lower buttons.
          if (bus.btn_start) begin
            if (!cnt_zero) begin
              preset_n = {min10, min1, sec10, sec1};
              state_n  = ST_RUN;
            end
          end else if (bus.btn_min) begin
            cnt_inc_min = 1'b1;
          end else if (bus.btn_sec) begin
            cnt_inc_sec = 1'b1;
          end
        end
        ST_RUN: begin
          // Pausing wins over a coincident strobe, which is simply lost.
          if (bus.btn_start) begin
            state_n = ST_PAUSE;
          end else if (bus.clk_sec) begin
            cnt_dec = 1'b1;
            if (cnt_one || cnt_zero) begin
              state_n     = ST_ALARM;
              done_n      = 1'b1;
              alarm_cnt_n = 4'd0;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.btn_start) begin
            state_n = ST_RUN;
          end
        end
        ST_ALARM: begin
          // Any user button acknowledges the alarm; its own action is dropped.
          if (bus.btn_start || bus.btn_min || bus.btn_sec) begin
            state_n     = ST_IDLE;
            alarm_cnt_n = 4'd0;
            cnt_load    = 1'b1;
          end else if (bus.clk_sec) begin
            if (alarm_cnt_q == ALARM_LAST) begin
              state_n     = ST_IDLE;
              alarm_cnt_n = 4'd0;
              cnt_load    = 1'b1;
            end else begin
              alarm_cnt_n = alarm_cnt_q + 4'd1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.min10 = min10;
  assign bus.min1  = min1;
  assign bus.sec10 = sec10;
  assign bus.sec1  = sec1;
  assign bus.state = state_q;
  assign bus.alarm = alarm_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed bench for cook_timer_ctrl: inputs change on the falling edge,
// outputs are checked on the following falling edge.
module tb_cook_timer_ctrl;

  logic clk;
  logic reset_p;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  cook_timer_ctrl_if bus ();

  cook_timer_ctrl #(.ALARM_SEC(5)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: hold the given inputs for exactly one rising edge.
  task automatic cyc(input logic st, input logic mn, input logic sc,
                     input logic clr, input logic tick, input logic rst);
    bus.btn_start = st;
    bus.btn_min   = mn;
    bus.btn_sec   = sc;
    bus.btn_clear = clr;
    bus.clk_sec   = tick;
    reset_p       = rst;
    @(negedge clk);
    bus.btn_start = 1'b0;
    bus.btn_min   = 1'b0;
    bus.btn_sec   = 1'b0;
    bus.btn_clear = 1'b0;
    bus.clk_sec   = 1'b0;
    reset_p       = 1'b0;
  endtask

  task automatic press_start(); cyc(1, 0, 0, 0, 0, 0); endtask
  task automatic press_min();   cyc(0, 1, 0, 0, 0, 0); endtask
  task automatic press_sec();   cyc(0, 0, 1, 0, 0, 0); endtask
  task automatic press_clear(); cyc(0, 0, 0, 1, 0, 0); endtask
  task automatic tick();        cyc(0, 0, 0, 0, 1, 0); endtask
  task automatic idle();        cyc(0, 0, 0, 0, 0, 0); endtask

  // Scoreboard checks.
  task automatic chk_time(input string tag, input logic [15:0] exp);
    logic [15:0] got;
    got = {bus.min10, bus.min1, bus.sec10, bus.sec1};
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: time got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    n_checks++;
    assert (bus.state === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: state got %b expected %b", tag, bus.state, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_ALARM = 2'b11;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    bus.btn_start = 1'b0;
    bus.btn_min   = 1'b0;
    bus.btn_sec   = 1'b0;
    bus.btn_clear = 1'b0;
    bus.clk_sec   = 1'b0;
    reset_p       = 1'b1;
    repeat (3) @(negedge clk);
    reset_p = 1'b0;

    // Reset values.
    chk_time("rst_time", 16'h0000);
    chk_state("rst_state", S_IDLE);
    chk_bit("rst_alarm", bus.alarm, 1'b0);
    chk_bit("rst_done", bus.done, 1'b0);

    // Set 03:02, run, borrow across sec10 and minutes.
    repeat (3) press_min();
    repeat (2) press_sec();
    chk_time("set_0302", 16'h0302);
    press_start();
    chk_state("start_run", S_RUN);
    chk_time("start_0302", 16'h0302);
    tick();
    chk_time("run_0301", 16'h0301);
    tick();
    chk_time("run_0300", 16'h0300);
    tick();
    chk_time("run_0259", 16'h0259);

    // Expiry into ALARM, then auto-timeout back to the preset.
    press_clear();
    chk_state("clr_idle", S_IDLE);
    chk_time("clr_0000", 16'h0000);
    repeat (2) press_sec();
    press_start();
    chk_state("run2", S_RUN);
    tick();
    chk_time("run_0001", 16'h0001);
    chk_bit("done_early", bus.done, 1'b0);
    tick();
    chk_time("expire_0000", 16'h0000);
    chk_bit("done_pulse", bus.done, 1'b1);
    chk_state("alarm_state", S_ALARM);
    chk_bit("alarm_on", bus.alarm, 1'b1);
    idle();
    chk_bit("done_one_cycle", bus.done, 1'b0);
    chk_bit("alarm_held", bus.alarm, 1'b1);
    repeat (4) tick();
    chk_state("alarm_4ticks", S_ALARM);
    chk_time("alarm_digits", 16'h0000);
    tick();
    chk_state("alarm_timeout", S_IDLE);
    chk_time("alarm_reload", 16'h0002);
    chk_bit("alarm_off", bus.alarm, 1'b0);

    // Pause with a coincident strobe, frozen digits, resume.
    press_clear();
    press_min();
    press_start();
    chk_time("run_0100", 16'h0100);
    cyc(1, 0, 0, 0, 1, 0);
    chk_state("pause", S_PAUSE);
    chk_time("pause_drop_tick", 16'h0100);
    repeat (3) tick();
    press_min();
    press_sec();
    chk_time("pause_frozen", 16'h0100);
    chk_state("pause_hold", S_PAUSE);
    press_start();
    chk_state("resume", S_RUN);
    tick();
    chk_time("resume_0059", 16'h0059);

    // Wrap at 59:59 in IDLE; start at 00:00 is ignored.
    press_clear();
    for (int i = 0; i < 59; i++) press_min();
    for (int i = 0; i < 59; i++) press_sec();
    chk_time("set_5959", 16'h5959);
    press_sec();
    chk_time("sec_wrap", 16'h5900);
    press_min();
    chk_time("min_wrap", 16'h0000);
    press_start();
    chk_state("start_at_zero", S_IDLE);

    // Clear beats start; preset is wiped.
    for (int i = 0; i < 10; i++) press_min();
    press_start();
    chk_state("run_1000", S_RUN);
    cyc(1, 0, 0, 1, 0, 0);
    chk_state("clear_wins", S_IDLE);
    chk_time("clear_wins_t", 16'h0000);
    press_start();
    chk_state("start_after_clr", S_IDLE);

    // Button exit from ALARM reloads preset without its own action.
    press_sec();
    press_start();
    tick();
    chk_state("alarm2", S_ALARM);
    press_min();
    chk_state("btn_exit", S_IDLE);
    chk_time("btn_exit_preset", 16'h0001);

    // Reset in RUN.
    press_start();
    chk_state("run3", S_RUN);
    cyc(0, 0, 0, 0, 0, 1);
    chk_state("rst_run_state", S_IDLE);
    chk_time("rst_run_time", 16'h0000);
    chk_bit("rst_run_alarm", bus.alarm, 1'b0);

    // Reset in ALARM drops alarm and preset.
    press_sec();
    press_start();
    tick();
    chk_bit("alarm3", bus.alarm, 1'b1);
    cyc(0, 0, 0, 0, 0, 1);
    chk_bit("rst_alarm_off", bus.alarm, 1'b0);
    chk_state("rst_alarm_state", S_IDLE);
    press_start();
    chk_state("preset_lost", S_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
